// File: rtl/mips_pkg.sv
// Shared MIPS encodings: ALU control codes, main-decoder aluop classes,
// R-type funct values and I-type opcodes used by the EX-side logic.
package mips_pkg;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;
  localparam logic [3:0] ALU_BAD = 4'd15;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [5:0] OPC_ADDI = 6'h08;
  localparam logic [5:0] OPC_SLTI = 6'h0A;
  localparam logic [5:0] OPC_ANDI = 6'h0C;
  localparam logic [5:0] OPC_ORI  = 6'h0D;

endpackage

// File: rtl/alu_control_decode.sv
// Combinational ALU control decode: aluop class plus funct/opcode to a
// 4-bit ALU code, flagging encodings the ALU does not support.
module alu_control_decode
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  input  logic [5:0] opcode,
  output logic [3:0] aluControl,
  output logic       illegal
);

  always_comb begin
    aluControl = ALU_ADD;
    illegal    = 1'b0;
    case (aluop)
      ALUOP_ADD: aluControl = ALU_ADD;
      ALUOP_SUB: aluControl = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: aluControl = ALU_ADD;
          FUNCT_SUB: aluControl = ALU_SUB;
          FUNCT_AND: aluControl = ALU_AND;
          FUNCT_OR:  aluControl = ALU_OR;
          FUNCT_NOR: aluControl = ALU_NOR;
          FUNCT_SLT: aluControl = ALU_SLT;
          default: begin
            aluControl = ALU_BAD;
            illegal    = 1'b1;
          end
        endcase
      end
      default: begin
        case (opcode)
          OPC_ADDI: aluControl = ALU_ADD;
          OPC_ANDI: aluControl = ALU_AND;
          OPC_ORI:  aluControl = ALU_OR;
          OPC_SLTI: aluControl = ALU_SLT;
          default: begin
            aluControl = ALU_BAD;
            illegal    = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU control decode, immediate extension and
// EX/MEM, MEM/WB operand forwarding feeding the ALU directly.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int FWD_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic              id_stall,
  input  logic              id_flush,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [15:0]       id_imm16,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [5:0]        id_opcode,
  input  logic [5:0]        id_funct,
  input  logic [1:0]        id_aluop,
  input  logic              id_alusrc,
  input  logic              id_regdst,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_memtoreg,
  input  logic              id_branch,
  input  logic              exmem_regwrite,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_regwrite,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  output logic [DATA_W-1:0] ex_operand_a,
  output logic [DATA_W-1:0] ex_operand_b,
  output logic [3:0]        ex_alu_control,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_write_reg,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_memtoreg,
  output logic              ex_branch,
  output logic              ex_valid,
  output logic              ex_illegal
);

  logic [3:0]        decCode;
  logic              decIllegal;
  logic [DATA_W-1:0] immExt;

  alu_control_decode uDecode (
    .aluop      (id_aluop),
    .funct      (id_funct),
    .opcode     (id_opcode),
    .aluControl (decCode),
    .illegal    (decIllegal)
  );

  // Logical immediates (andi/ori) are zero-extended; everything else sign-extends.
  always_comb begin
    if (id_opcode == OPC_ANDI || id_opcode == OPC_ORI)
      immExt = {{(DATA_W-16){1'b0}}, id_imm16};
    else
      immExt = {{(DATA_W-16){id_imm16[15]}}, id_imm16};
  end

  logic [DATA_W-1:0] rsDataQ, rtDataQ, immQ;
  logic [REG_AW-1:0] rsQ, rtQ, writeRegQ;
  logic [3:0]        aluControlQ;
  logic              validQ, regwriteQ, memreadQ, memwriteQ, memtoregQ, branchQ;
  logic              alusrcQ, illegalQ;

  always_ff @(posedge clk) begin
    if (reset) begin
      rsDataQ     <= '0;
      rtDataQ     <= '0;
      immQ        <= '0;
      rsQ         <= '0;
      rtQ         <= '0;
      writeRegQ   <= '0;
      aluControlQ <= ALU_ADD;
      validQ      <= 1'b0;
      regwriteQ   <= 1'b0;
      memreadQ    <= 1'b0;
      memwriteQ   <= 1'b0;
      memtoregQ   <= 1'b0;
      branchQ     <= 1'b0;
      alusrcQ     <= 1'b0;
      illegalQ    <= 1'b0;
    end else if (id_flush) begin
      validQ    <= 1'b0;
      regwriteQ <= 1'b0;
      memreadQ  <= 1'b0;
      memwriteQ <= 1'b0;
      branchQ   <= 1'b0;
      illegalQ  <= 1'b0;
    end else if (!id_stall) begin
      rsDataQ     <= id_rs_data;
      rtDataQ     <= id_rt_data;
      immQ        <= immExt;
      rsQ         <= id_rs;
      rtQ         <= id_rt;
      writeRegQ   <= id_regdst ? id_rd : id_rt;
      aluControlQ <= decCode;
      validQ      <= id_valid;
      // An unsupported encoding must not have side effects downstream.
      regwriteQ   <= id_regwrite & ~decIllegal;
      memreadQ    <= id_memread  & ~decIllegal;
      memwriteQ   <= id_memwrite & ~decIllegal;
      branchQ     <= id_branch   & ~decIllegal;
      memtoregQ   <= id_memtoreg;
      alusrcQ     <= id_alusrc;
      illegalQ    <= decIllegal;
    end
  end

  logic [DATA_W-1:0] fwdA, fwdB;

  // EX/MEM is younger than MEM/WB, so it takes priority; r0 is never forwarded.
  always_comb begin
    fwdA = rsDataQ;
    fwdB = rtDataQ;
    if (FWD_EN != 0) begin
      if (exmem_regwrite && exmem_rd != '0 && exmem_rd == rsQ)
        fwdA = exmem_result;
      else if (memwb_regwrite && memwb_rd != '0 && memwb_rd == rsQ)
        fwdA = memwb_data;
      if (exmem_regwrite && exmem_rd != '0 && exmem_rd == rtQ)
        fwdB = exmem_result;
      else if (memwb_regwrite && memwb_rd != '0 && memwb_rd == rtQ)
        fwdB = memwb_data;
    end
  end

  assign ex_operand_a   = fwdA;
  assign ex_operand_b   = alusrcQ ? immQ : fwdB;
  assign ex_store_data  = fwdB;
  assign ex_alu_control = aluControlQ;
  assign ex_write_reg   = writeRegQ;
  assign ex_regwrite    = regwriteQ;
  assign ex_memread     = memreadQ;
  assign ex_memwrite    = memwriteQ;
  assign ex_memtoreg    = memtoregQ;
  assign ex_branch      = branchQ;
  assign ex_valid       = validQ;
  assign ex_illegal     = illegalQ;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic checked
// against a behavioural model of the ID/EX register and forwarding rules.
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              reset, id_valid, id_stall, id_flush;
  logic [DATA_W-1:0] id_rs_data, id_rt_data;
  logic [15:0]       id_imm16;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic [5:0]        id_opcode, id_funct;
  logic [1:0]        id_aluop;
  logic              id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite;
  logic              id_memtoreg, id_branch;
  logic              exmem_regwrite, memwb_regwrite;
  logic [REG_AW-1:0] exmem_rd, memwb_rd;
  logic [DATA_W-1:0] exmem_result, memwb_data;
  logic [DATA_W-1:0] ex_operand_a, ex_operand_b, ex_store_data;
  logic [3:0]        ex_alu_control;
  logic [REG_AW-1:0] ex_write_reg;
  logic              ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch;
  logic              ex_valid, ex_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_EN(1)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_stall(id_stall), .id_flush(id_flush),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm16(id_imm16),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_opcode(id_opcode), .id_funct(id_funct),
    .id_aluop(id_aluop), .id_alusrc(id_alusrc), .id_regdst(id_regdst),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_memtoreg(id_memtoreg), .id_branch(id_branch),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .ex_operand_a(ex_operand_a), .ex_operand_b(ex_operand_b), .ex_alu_control(ex_alu_control),
    .ex_store_data(ex_store_data), .ex_write_reg(ex_write_reg), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
    .ex_branch(ex_branch), .ex_valid(ex_valid), .ex_illegal(ex_illegal)
  );

  // Reference tables: the supported encodings and the ALU code each one selects.
  localparam logic [5:0] FN_TAB  [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
  localparam logic [3:0] FN_CODE [6] = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd12, 4'd7};
  localparam logic [5:0] OP_TAB  [4] = '{6'h08, 6'h0C, 6'h0D, 6'h0A};
  localparam logic [3:0] OP_CODE [4] = '{4'd2, 4'd0, 4'd1, 4'd7};

  // Model of what the EX stage currently holds.
  logic [DATA_W-1:0] mRsData, mRtData, mImm;
  logic [REG_AW-1:0] mRs, mRt, mWriteReg;
  logic [3:0]        mCode;
  logic              mValid, mRegwrite, mMemread, mMemwrite, mMemtoreg, mBranch;
  logic              mAlusrc, mIllegal;

  function automatic void refDecode(input logic [1:0] op, input logic [5:0] fn,
                                    input logic [5:0] opc, output logic [3:0] code,
                                    output logic bad);
    code = 4'd15;
    bad  = 1'b1;
    if (op == 2'd0) begin code = 4'd2; bad = 1'b0; end
    else if (op == 2'd1) begin code = 4'd6; bad = 1'b0; end
    else if (op == 2'd2) begin
      for (int i = 0; i < 6; i++)
        if (fn == FN_TAB[i]) begin code = FN_CODE[i]; bad = 1'b0; end
    end else begin
      for (int i = 0; i < 4; i++)
        if (opc == OP_TAB[i]) begin code = OP_CODE[i]; bad = 1'b0; end
    end
  endfunction

  function automatic logic [DATA_W-1:0] refFwd(input logic [REG_AW-1:0] src,
                                               input logic [DATA_W-1:0] held);
    if (exmem_regwrite && exmem_rd != 0 && exmem_rd == src) return exmem_result;
    if (memwb_regwrite && memwb_rd != 0 && memwb_rd == src) return memwb_data;
    return held;
  endfunction

  // Apply the model's view of the coming clock edge, then advance past it.
  task automatic tick();
    logic [3:0] code;
    logic       bad;
    if (reset) begin
      mRsData = 0; mRtData = 0; mImm = 0; mRs = 0; mRt = 0; mWriteReg = 0; mCode = 4'd2;
      mValid = 0; mRegwrite = 0; mMemread = 0; mMemwrite = 0; mMemtoreg = 0;
      mBranch = 0; mAlusrc = 0; mIllegal = 0;
    end else if (id_flush) begin
      mValid = 0; mRegwrite = 0; mMemread = 0; mMemwrite = 0; mBranch = 0; mIllegal = 0;
    end else if (!id_stall) begin
      refDecode(id_aluop, id_funct, id_opcode, code, bad);
      mRsData = id_rs_data; mRtData = id_rt_data; mRs = id_rs; mRt = id_rt;
      mImm = (id_opcode == 6'h0C || id_opcode == 6'h0D) ? {16'h0, id_imm16}
                                                        : {{16{id_imm16[15]}}, id_imm16};
      mWriteReg = id_regdst ? id_rd : id_rt;
      mCode = code; mIllegal = bad; mValid = id_valid;
      mRegwrite = id_regwrite && !bad; mMemread = id_memread && !bad;
      mMemwrite = id_memwrite && !bad; mBranch = id_branch && !bad;
      mMemtoreg = id_memtoreg; mAlusrc = id_alusrc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; id_valid = 0; id_stall = 0; id_flush = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm16 = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_opcode = 0; id_funct = 0; id_aluop = 0; id_alusrc = 0; id_regdst = 0;
    id_regwrite = 0; id_memread = 0; id_memwrite = 0; id_memtoreg = 0; id_branch = 0;
    exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
    memwb_regwrite = 0; memwb_rd = 0; memwb_data = 0;
  endtask

  task automatic randomizeId();
    id_valid    = 1'($urandom_range(0, 7) != 0);
    id_rs_data  = $urandom; id_rt_data = $urandom; id_imm16 = 16'($urandom);
    id_rs       = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7));
    id_rd       = 5'($urandom);
    id_aluop    = 2'($urandom_range(0, 3));
    id_funct    = ($urandom_range(0, 5) != 0) ? FN_TAB[$urandom_range(0, 5)] : 6'($urandom);
    id_opcode   = ($urandom_range(0, 4) != 0) ? OP_TAB[$urandom_range(0, 3)] : 6'($urandom);
    id_alusrc   = 1'($urandom); id_regdst = 1'($urandom); id_regwrite = 1'($urandom);
    id_memread  = 1'($urandom); id_memwrite = 1'($urandom);
    id_memtoreg = 1'($urandom); id_branch = 1'($urandom);
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    tick();
    tick();
    checks++;
    if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", ex_valid); end
    checks++;
    if (ex_regwrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %0b expected 0", ex_regwrite); end
    checks++;
    if (ex_alu_control !== 4'd2) begin errors++; $display("FAIL reset_alu_control: got %0d expected 2", ex_alu_control); end
    checks++;
    if (ex_write_reg !== 5'd0) begin errors++; $display("FAIL reset_write_reg: got %0d expected 0", ex_write_reg); end
    reset = 0;
  endtask

  task automatic test_rtype_sub();
    idle();
    id_valid = 1; id_aluop = 2'b10; id_funct = 6'h22; id_rs = 5; id_rt = 3; id_rd = 7;
    id_regdst = 1; id_regwrite = 1; id_rs_data = 32'h10; id_rt_data = 32'h3;
    tick();
    checks++;
    if (ex_alu_control !== 4'd6) begin errors++; $display("FAIL sub_alu_control: got %0d expected 6", ex_alu_control); end
    checks++;
    if (ex_write_reg !== 5'd7) begin errors++; $display("FAIL sub_write_reg: got %0d expected 7", ex_write_reg); end
    checks++;
    if (ex_valid !== 1'b1) begin errors++; $display("FAIL sub_valid: got %0b expected 1", ex_valid); end
    checks++;
    if (ex_operand_b !== 32'h3) begin errors++; $display("FAIL sub_operand_b: got %h expected 00000003", ex_operand_b); end
  endtask

  task automatic test_immediate();
    idle();
    id_valid = 1; id_aluop = 2'b11; id_opcode = 6'h08; id_alusrc = 1; id_imm16 = 16'hFFFC;
    tick();
    checks++;
    if (ex_operand_b !== 32'hFFFFFFFC) begin errors++; $display("FAIL addi_imm: got %h expected fffffffc", ex_operand_b); end
    id_opcode = 6'h0D;
    tick();
    checks++;
    if (ex_operand_b !== 32'h0000FFFC) begin errors++; $display("FAIL ori_imm: got %h expected 0000fffc", ex_operand_b); end
    checks++;
    if (ex_alu_control !== 4'd1) begin errors++; $display("FAIL ori_alu_control: got %0d expected 1", ex_alu_control); end
  endtask

  task automatic test_forwarding();
    idle();
    id_valid = 1; id_rs = 4; id_rs_data = 32'h1234;
    tick();
    idle();
    id_stall = 1;
    exmem_regwrite = 1; exmem_rd = 4; exmem_result = 32'hAAAA;
    memwb_regwrite = 1; memwb_rd = 4; memwb_data = 32'hBBBB;
    #1;
    checks++;
    if (ex_operand_a !== 32'hAAAA) begin errors++; $display("FAIL fwd_exmem_wins: got %h expected 0000aaaa", ex_operand_a); end
    exmem_regwrite = 0;
    #1;
    checks++;
    if (ex_operand_a !== 32'hBBBB) begin errors++; $display("FAIL fwd_memwb: got %h expected 0000bbbb", ex_operand_a); end
    exmem_regwrite = 1; exmem_rd = 0; memwb_rd = 0;
    #1;
    checks++;
    if (ex_operand_a !== 32'h1234) begin errors++; $display("FAIL fwd_r0_blocked: got %h expected 00001234", ex_operand_a); end
    id_stall = 0;
  endtask

  task automatic test_stall_flush();
    idle();
    id_valid = 1; id_aluop = 2'b10; id_funct = 6'h25; id_regdst = 1; id_rd = 9;
    id_regwrite = 1; id_rs_data = 32'hCAFE;
    tick();
    for (int i = 0; i < 3; i++) begin
      randomizeId();
      id_stall = 1;
      tick();
      checks++;
      if (ex_alu_control !== 4'd1 || ex_write_reg !== 5'd9 || ex_valid !== 1'b1 ||
          ex_regwrite !== 1'b1 || ex_operand_a !== 32'hCAFE)
        begin errors++; $display("FAIL stall_hold: got ctl=%0d wr=%0d v=%0b rw=%0b a=%h expected ctl=1 wr=9 v=1 rw=1 a=0000cafe",
                                 ex_alu_control, ex_write_reg, ex_valid, ex_regwrite, ex_operand_a); end
    end
    id_flush = 1;
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0)
      begin errors++; $display("FAIL stall_flush_bubble: got v=%0b rw=%0b expected v=0 rw=0", ex_valid, ex_regwrite); end
    idle();
    id_valid = 1; id_regwrite = 1;
    tick();
    id_stall = 1; reset = 1;
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0)
      begin errors++; $display("FAIL reset_in_stall: got v=%0b rw=%0b expected v=0 rw=0", ex_valid, ex_regwrite); end
    idle();
  endtask

  task automatic test_illegal();
    idle();
    id_valid = 1; id_aluop = 2'b10; id_funct = 6'h18; id_regwrite = 1; id_memwrite = 1;
    tick();
    checks++;
    if (ex_alu_control !== 4'd15) begin errors++; $display("FAIL illegal_code: got %0d expected 15", ex_alu_control); end
    checks++;
    if (ex_illegal !== 1'b1) begin errors++; $display("FAIL illegal_flag: got %0b expected 1", ex_illegal); end
    checks++;
    if (ex_regwrite !== 1'b0 || ex_memwrite !== 1'b0)
      begin errors++; $display("FAIL illegal_ctrl_off: got rw=%0b mw=%0b expected 0 0", ex_regwrite, ex_memwrite); end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] expStore;
    for (int n = 0; n < 400; n++) begin
      randomizeId();
      reset    = 1'($urandom_range(0, 39) == 0);
      id_stall = 1'($urandom_range(0, 4) == 0);
      id_flush = 1'($urandom_range(0, 9) == 0);
      tick();
      exmem_regwrite = 1'($urandom); exmem_rd = 5'($urandom_range(0, 7)); exmem_result = $urandom;
      memwb_regwrite = 1'($urandom); memwb_rd = 5'($urandom_range(0, 7)); memwb_data = $urandom;
      #1;
      expStore = refFwd(mRt, mRtData);
      checks++;
      if (ex_operand_a !== refFwd(mRs, mRsData))
        begin errors++; $display("FAIL rand_operand_a[%0d]: got %h expected %h", n, ex_operand_a, refFwd(mRs, mRsData)); end
      checks++;
      if (ex_store_data !== expStore)
        begin errors++; $display("FAIL rand_store_data[%0d]: got %h expected %h", n, ex_store_data, expStore); end
      checks++;
      if (ex_operand_b !== (mAlusrc ? mImm : expStore))
        begin errors++; $display("FAIL rand_operand_b[%0d]: got %h expected %h", n, ex_operand_b, mAlusrc ? mImm : expStore); end
      checks++;
      if (ex_alu_control !== mCode || ex_illegal !== mIllegal)
        begin errors++; $display("FAIL rand_decode[%0d]: got ctl=%0d ill=%0b expected ctl=%0d ill=%0b",
                                 n, ex_alu_control, ex_illegal, mCode, mIllegal); end
      checks++;
      if (ex_write_reg !== mWriteReg)
        begin errors++; $display("FAIL rand_write_reg[%0d]: got %0d expected %0d", n, ex_write_reg, mWriteReg); end
      checks++;
      if ({ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch} !==
          {mValid, mRegwrite, mMemread, mMemwrite, mMemtoreg, mBranch})
        begin errors++; $display("FAIL rand_controls[%0d]: got %b expected %b", n,
          {ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch},
          {mValid, mRegwrite, mMemread, mMemwrite, mMemtoreg, mBranch}); end
    end
  endtask

  initial begin
    test_reset();
    test_rtype_sub();
    test_immediate();
    test_forwarding();
    test_stall_flush();
    test_illegal();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
